// File: rtl/event_edge_conditioner_pkg.sv
// event_edge_pkg: shared register offsets, mode encodings and line count for the event edge conditioner
//   Register offsets are PADDR[4:2] word indices; modes are the 2-bit per-line edge selections.
package event_edge_pkg;

    localparam int NUM_EVENTS = 32;

    typedef enum logic [2:0] {
        MODE_LO = 3'd0,
        MODE_HI = 3'd1,
        STATUS  = 3'd2,
        SWTRIG  = 3'd3,
        RAW     = 3'd4
    } reg_e;

    typedef enum logic [1:0] {
        MODE_OFF  = 2'b00,
        MODE_RISE = 2'b01,
        MODE_FALL = 2'b10,
        MODE_BOTH = 2'b11
    } mode_e;

endpackage

// File: rtl/event_edge_conditioner_if.sv
// event_edge_conditioner_if: APB bus bundle between a bus master and the event edge conditioner
//   master: drives PADDR, PWDATA, PWRITE, PSEL, PENABLE; receives PRDATA, PREADY, PSLVERR
//   slave:  receives PADDR, PWDATA, PWRITE, PSEL, PENABLE; drives PRDATA, PREADY, PSLVERR
interface event_edge_conditioner_if #(
    parameter int ADDR_WIDTH = 12
) ();

    logic [ADDR_WIDTH-1:0] PADDR;
    logic [31:0]           PWDATA;
    logic                  PWRITE;
    logic                  PSEL;
    logic                  PENABLE;
    logic [31:0]           PRDATA;
    logic                  PREADY;
    logic                  PSLVERR;

    modport master (
        output PADDR, PWDATA, PWRITE, PSEL, PENABLE,
        input  PRDATA, PREADY, PSLVERR
    );

    modport slave (
        input  PADDR, PWDATA, PWRITE, PSEL, PENABLE,
        output PRDATA, PREADY, PSLVERR
    );

endinterface

// File: rtl/event_edge_conditioner_sync_cell.sv
// event_sync_cell: one event line -- synchronizer chain, previous-level flop and mode-selected edge detect
//   HCLK, HRESETn : clock and asynchronous active-low reset
//   event_i       : raw asynchronous event line
//   mode          : 2-bit edge mode (off / rise / fall / both)
//   sync_o        : synchronized level of the line
//   det_o         : combinational edge detect for the current cycle
module event_sync_cell
    import event_edge_pkg::*;
#(
    parameter int SYNC_STAGES = 2
) (
    input  logic       HCLK,
    input  logic       HRESETn,
    input  logic       event_i,
    input  logic [1:0] mode,
    output logic       sync_o,
    output logic       det_o
);

    if (SYNC_STAGES < 2) begin : g_bad_stages
        $error("event_sync_cell: SYNC_STAGES must be at least 2");
    end

    logic [SYNC_STAGES-1:0] chain;
    logic                   prev;

    // prev follows sync every cycle whatever the mode, so enabling a mode never sees stale history
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            chain <= '0;
            prev  <= 1'b0;
        end else begin
            chain <= {chain[SYNC_STAGES-2:0], event_i};
            prev  <= chain[SYNC_STAGES-1];
        end
    end

    assign sync_o = chain[SYNC_STAGES-1];
    assign det_o  = ((mode == MODE_RISE || mode == MODE_BOTH) && sync_o && !prev) ||
                    ((mode == MODE_FALL || mode == MODE_BOTH) && !sync_o && prev);

endmodule

// File: rtl/event_edge_conditioner.sv
// event_edge_conditioner: synchronizes 32 event lines, detects per-line edges and emits one-cycle pulses
//   HCLK, HRESETn : clock and asynchronous active-low reset
//   apb           : APB slave (MODE_LO, MODE_HI, STATUS W1C, SWTRIG write-only, RAW read-only)
//   event_i       : raw asynchronous event lines
//   signal_o      : registered one-cycle event pulses for the service unit
module event_edge_conditioner
    import event_edge_pkg::*;
#(
    parameter int APB_ADDR_WIDTH = 12,
    parameter int SYNC_STAGES    = 2
) (
    input  logic                    HCLK,
    input  logic                    HRESETn,
    event_edge_conditioner_if.slave apb,
    input  logic [NUM_EVENTS-1:0]   event_i,
    output logic [NUM_EVENTS-1:0]   signal_o
);

    logic [2:0]              addr;
    logic                    wr;
    logic                    rd;
    logic [31:0]             mode_lo;
    logic [31:0]             mode_hi;
    logic [NUM_EVENTS-1:0]   status;
    logic [NUM_EVENTS-1:0]   raw;
    logic [NUM_EVENTS-1:0]   det;
    logic [NUM_EVENTS-1:0]   w1c;
    logic [NUM_EVENTS-1:0]   swtrig;
    logic [2*NUM_EVENTS-1:0] modes;
    logic                    unused_paddr;

    assign addr         = apb.PADDR[4:2];
    assign wr           = apb.PSEL && apb.PENABLE && apb.PWRITE;
    assign rd           = apb.PSEL && apb.PENABLE && !apb.PWRITE;
    assign unused_paddr = ^{apb.PADDR[APB_ADDR_WIDTH-1:5], apb.PADDR[1:0]};
    assign modes        = {mode_hi, mode_lo};

    for (genvar i = 0; i < NUM_EVENTS; i++) begin : g_line
        event_sync_cell #(
            .SYNC_STAGES(SYNC_STAGES)
        ) u_cell (
            .HCLK    (HCLK),
            .HRESETn (HRESETn),
            .event_i (event_i[i]),
            .mode    (modes[2*i +: 2]),
            .sync_o  (raw[i]),
            .det_o   (det[i])
        );
    end

    // Software trigger data goes straight into signal_o at the edge that completes the write
    assign w1c    = (wr && addr == STATUS) ? apb.PWDATA : '0;
    assign swtrig = (wr && addr == SWTRIG) ? apb.PWDATA : '0;

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            mode_lo  <= '0;
            mode_hi  <= '0;
            status   <= '0;
            signal_o <= '0;
        end else begin
            if (wr && addr == MODE_LO) mode_lo <= apb.PWDATA;
            if (wr && addr == MODE_HI) mode_hi <= apb.PWDATA;
            // a fresh detection beats a simultaneous W1C on the same bit
            status   <= (status & ~w1c) | det;
            signal_o <= det | swtrig;
        end
    end

    assign apb.PRDATA  = !rd              ? '0      :
                         addr == MODE_LO  ? mode_lo :
                         addr == MODE_HI  ? mode_hi :
                         addr == STATUS   ? status  :
                         addr == RAW      ? raw     : '0;
    assign apb.PREADY  = 1'b1;
    assign apb.PSLVERR = 1'b0;

endmodule

// File: doc/event_edge_conditioner.md
Name: event_edge_conditioner

Overview:
Upstream front-end for the APB event/service unit. It takes 32 raw, possibly asynchronous event lines and synchronizes each one. Each line then passes through an edge detector whose mode is set per line over APB. The block produces one-cycle event pulses on signal_o, which connects directly to the service unit's signal_i. It also keeps sticky capture status and a software trigger for firmware-generated events.

Parameters:
APB_ADDR_WIDTH, 12, APB address width (4KB slave window).
SYNC_STAGES, 2, synchronizer flop depth per line; legal values are 2 or greater. Elaboration fails for values below 2.

Ports:
HCLK  in  1  single clock.
HRESETn  in  1  asynchronous, active-low reset.
PADDR  in  APB_ADDR_WIDTH  APB address; only PADDR[4:2] is decoded.
PWDATA  in  32  APB write data.
PWRITE  in  1  APB write strobe.
PSEL  in  1  APB select.
PENABLE  in  1  APB enable.
PRDATA  out  32  APB read data.
PREADY  out  1  tied to 1.
PSLVERR  out  1  tied to 0.
event_i  in  32  raw event lines, asynchronous to HCLK.
signal_o  out  32  registered event pulses sent to the service unit.

Behaviour:
- Clocking and reset: one clock, HCLK. Reset is asynchronous and active-low on HRESETn. On reset, every flop clears to 0: synchronizer chains, previous-level register, MODE_LO/HI, STATUS, software-trigger register and signal_o.
- APB access:
  - Write occurs when PSEL && PENABLE && PWRITE. Read data is valid when PSEL && PENABLE && !PWRITE.
  - PRDATA is combinational and is 0 outside a read access.
  - There are no wait states.
- Register map (PADDR[4:2]):
  - 0 = MODE_LO (0x00): 2 bits per line, lines 0..15. Line n uses bits [2n+1:2n].
  - 1 = MODE_HI (0x04): lines 16..31. Line n uses bits [2(n-16)+1:2(n-16)].
  - 2 = STATUS (0x08): sticky detected events. Read returns the bits. Writing 1 clears a bit (W1C).
  - 3 = SWTRIG (0x0C): write only. Reads return 0.
  - 4 = RAW (0x10): read only. Returns the synchronized levels of the lines.
  - 5..7: reads return 0. Writes are ignored.
- Mode encoding per line:
  - 00 = off
  - 01 = rising edge
  - 10 = falling edge
  - 11 = both edges
- Synchronizer:
  - Each line passes through SYNC_STAGES flops; the last flop is sync[n].
  - prev[n] is registered from sync[n] every cycle, regardless of mode.
  - Because prev always tracks sync, a mode change never creates a pulse from stale history.
- Detection (combinational): det[n] = (mode bit0 & sync & ~prev) | (mode bit1 & ~sync & prev).
- Output: signal_o <= det | swtrig_pulse. It is registered, so each pulse lasts exactly one cycle per detected edge.
- Latency: an event_i transition set up before HCLK edge k appears on signal_o during the cycle following edge k+SYNC_STAGES.
  - Example with SYNC_STAGES = 2: the pulse is high from edge k+2 to edge k+3.
- Software trigger: an SWTRIG write with data D makes signal_o |= D for exactly one cycle, starting at the clock edge that completes the write access.
  - The pulse is independent of the line mode.
  - It does not set STATUS.
- STATUS: status <= (status & ~w1c_mask) | det, updated at the same edge that sets signal_o.
  - If W1C and a new detection hit the same bit in the same cycle, the set wins and the bit stays 1.
- Boundary conditions:
  - Pulses narrower than one HCLK period may be missed; this is allowed.
  - Toggling at the HCLK rate in both-edges mode produces a pulse every cycle.
  - Modes reset to off, so a line held high through reset release produces no pulse.
  - Reset asserted mid-pulse clears signal_o immediately (asynchronous).

Decomposition:
- Shared package event_edge_pkg holds:
  - register offsets: MODE_LO, MODE_HI, STATUS, SWTRIG, RAW;
  - mode encodings: MODE_OFF, MODE_RISE, MODE_FALL, MODE_BOTH;
  - the NUM_EVENTS = 32 constant.
- Sub-module event_sync_cell implements one line: a SYNC_STAGES synchronizer, the prev flop, and the det output from a 2-bit mode input. It is instantiated 32 times with a generate loop.
- The top level holds the APB decode, the registers, STATUS and the signal_o register.

Test Plan:
1. Reset, then toggle all event_i lines for 20 cycles -> signal_o stays 0; MODE_LO, MODE_HI and STATUS read 0; RAW follows event_i 2 cycles late.
2. Write MODE_LO = 0x0000_0040 (line 3 rising); drive event_i[3] 0->1 before edge k -> signal_o = 0x0000_0008 from edge k+2 to k+3 only; STATUS reads 0x8; write STATUS = 0x8 -> STATUS reads 0; driving the line 1->0 produces no pulse.
3. Write MODE_HI = 0x0000_000C (line 17 both edges); drive event_i[17] high, then low 5 cycles later -> two one-cycle pulses on signal_o[17], spaced 5 cycles apart.
4. Line 3 in rising mode with STATUS bit 3 already set; apply a W1C of 0x8 on the same edge a new rising edge is detected -> STATUS bit 3 remains 1.
5. All modes off; write SWTRIG = 0x8000_0001 -> signal_o = 0x8000_0001 for exactly one cycle; STATUS remains 0; reading SWTRIG returns 0.
6. Hold event_i[5] high, then write line 5 mode = rising -> no pulse; drop the line and raise it again -> one pulse; assert HRESETn low during the pulse -> signal_o clears immediately and MODE returns to 0.
